// File: rtl/sdith_prng_pkg.sv
//------------------------------------------------------------------------------
// sdith_prng_pkg
// Definitions shared by the AES-CTR PRNG consumers.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sdith_prng_pkg;

  localparam int BLK_W      = 128;
  localparam int DEF_ELEM_W = 8;
  localparam int DEF_Q      = 251;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } sampler_state_t;

endpackage

`default_nettype wire

// File: rtl/prng_blk_slicer.sv
//------------------------------------------------------------------------------
// prng_blk_slicer
// Buffers one PRNG block and presents its slots LSB first, one per advance.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module prng_blk_slicer
  import sdith_prng_pkg::*;
#(
  parameter int ELEM_W = DEF_ELEM_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [BLK_W-1:0]  i_blk,
  input  logic              i_adv,
  output logic [ELEM_W-1:0] o_cand,
  output logic              o_last
);

  localparam int ELEMS = BLK_W / ELEM_W;
  localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;

  logic [BLK_W-1:0]  r_buf;
  logic [IDX_W-1:0]  r_idx;
  logic [ELEM_W-1:0] w_slots [ELEMS];

  generate
    for (genvar k = 0; k < ELEMS; k++) begin : g_slot
      assign w_slots[k] = r_buf[k*ELEM_W +: ELEM_W];
    end
  endgenerate

  assign o_cand = w_slots[r_idx];
  assign o_last = (r_idx == IDX_W'(ELEMS - 1));

  // A fresh load always restarts at slot 0, so leftovers never leak across blocks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf <= '0;
      r_idx <= '0;
    end else if (i_load) begin
      r_buf <= i_blk;
      r_idx <= '0;
    end else if (i_adv) begin
      r_idx <= r_idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/prng_rej_sampler.sv
//------------------------------------------------------------------------------
// prng_rej_sampler
// Rejection-samples PRNG block slots against Q and streams accepted elements.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module prng_rej_sampler
  import sdith_prng_pkg::*;
#(
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int Q      = DEF_Q,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_n_elems,
  input  logic              i_blk_valid,
  input  logic [BLK_W-1:0]  i_blk,
  output logic              o_blk_ready,
  output logic              o_elem_valid,
  output logic [ELEM_W-1:0] o_elem,
  input  logic              i_elem_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_rej_cnt
);

  // One extra bit so that Q = 2^ELEM_W (never reject) is representable.
  localparam logic [ELEM_W:0] c_q = (ELEM_W + 1)'(Q);

  sampler_state_t    r_state, w_next;
  logic [CNT_W-1:0]  r_remaining;
  logic [CNT_W-1:0]  r_rej_cnt;
  logic [ELEM_W-1:0] w_cand;
  logic              w_last;
  logic              w_accept;
  logic              w_load;
  logic              w_adv;
  logic              w_dec;
  logic              w_rej;
  logic              w_elem_valid;

  prng_blk_slicer #(
    .ELEM_W (ELEM_W)
  ) u_slicer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_load),
    .i_blk  (i_blk),
    .i_adv  (w_adv),
    .o_cand (w_cand),
    .o_last (w_last)
  );

  assign w_accept = ({1'b0, w_cand} < c_q);

  always_comb begin
    w_next       = r_state;
    o_blk_ready  = 1'b0;
    w_elem_valid = 1'b0;
    w_load       = 1'b0;
    w_adv        = 1'b0;
    w_dec        = 1'b0;
    w_rej        = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next = (i_n_elems == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        o_blk_ready = 1'b1;
        if (i_blk_valid) begin
          w_load = 1'b1;
          w_next = SCAN;
        end
      end
      SCAN: begin
        if (!w_accept) begin
          w_rej = 1'b1;
          w_adv = 1'b1;
          if (w_last) begin
            w_next = FETCH;
          end
        end else begin
          w_elem_valid = 1'b1;
          if (i_elem_ready) begin
            w_dec = 1'b1;
            w_adv = 1'b1;
            if (r_remaining == CNT_W'(1)) begin
              w_next = DONE;
            end else if (w_last) begin
              w_next = FETCH;
            end
          end
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_rej_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && i_start) begin
        r_remaining <= i_n_elems;
        r_rej_cnt   <= '0;
      end else begin
        if (w_dec) begin
          r_remaining <= r_remaining - 1'b1;
        end
        if (w_rej && (r_rej_cnt != '1)) begin
          r_rej_cnt <= r_rej_cnt + 1'b1;
        end
      end
    end
  end

  assign o_elem_valid = w_elem_valid;
  assign o_elem       = w_elem_valid ? w_cand : '0;
  assign o_busy       = (r_state != IDLE);
  assign o_done       = (r_state == DONE);
  assign o_rej_cnt    = r_rej_cnt;

endmodule

`default_nettype wire

// File: tb/tb_prng_rej_sampler.sv
//------------------------------------------------------------------------------
// tb_prng_rej_sampler
// Directed and randomized requests checked against a slot-walking reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_prng_rej_sampler;

  localparam int ELEM_W = 8;
  localparam int Q      = 251;
  localparam int CNT_W  = 16;
  localparam int ELEMS  = 128 / ELEM_W;
  localparam int NBLK   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  n_elems;
  logic              blk_valid;
  logic [127:0]      blk;
  logic              blk_ready;
  logic              elem_valid;
  logic [ELEM_W-1:0] elem;
  logic              elem_ready;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  rej_cnt;

  prng_rej_sampler #(
    .ELEM_W (ELEM_W),
    .Q      (Q),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_n_elems    (n_elems),
    .i_blk_valid  (blk_valid),
    .i_blk        (blk),
    .o_blk_ready  (blk_ready),
    .o_elem_valid (elem_valid),
    .o_elem       (elem),
    .i_elem_ready (elem_ready),
    .o_busy       (busy),
    .o_done       (done),
    .o_rej_cnt    (rej_cnt)
  );

  always #5 clk = ~clk;

  logic [127:0] blocks [NBLK];
  int           q_exp[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           exp_blocks, exp_rej, exp_scan;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Walk the blocks slot by slot, keeping values below Q until n are collected.
  task automatic model(input int n);
    int got;
    int v;
    q_exp.delete();
    got = 0; exp_blocks = 0; exp_rej = 0; exp_scan = 0;
    for (int b = 0; b < NBLK && got < n; b++) begin
      exp_blocks++;
      for (int k = 0; k < ELEMS && got < n; k++) begin
        v = int'(blocks[b][k*ELEM_W +: ELEM_W]);
        exp_scan++;
        if (v < Q) begin
          q_exp.push_back(v);
          got++;
        end else begin
          exp_rej++;
        end
      end
    end
  endtask

  // mode 0: always ready; 1: random ready; 2: first five valid cycles stalled.
  task automatic run_req(input string tag, input int n, input int mode);
    int bi, got_blocks, got_elems, done_cyc, stall_left;
    bit xfer, hold;
    logic [ELEM_W-1:0] held;
    model(n);
    bi = 0; got_blocks = 0; got_elems = 0; done_cyc = -1;
    stall_left = 5; hold = 1'b0; held = '0;
    start      = 1'b1;
    n_elems    = CNT_W'(n);
    blk_valid  = 1'b1;
    blk        = blocks[0];
    elem_ready = (mode == 2) ? 1'b0 : ((mode == 1) ? 1'($urandom) : 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      xfer = blk_ready && blk_valid;
      if (xfer) got_blocks++;
      if (hold) begin
        check({tag, " held_valid"}, 32'(elem_valid), 32'd1);
        check({tag, " held_elem"}, 32'(elem), 32'(held));
      end
      hold = elem_valid && !elem_ready;
      held = elem;
      if (elem_valid && !elem_ready && stall_left > 0) stall_left--;
      if (elem_valid && elem_ready) begin
        got_elems++;
        if (q_exp.size() == 0) check({tag, " extra_elem"}, 32'(elem), 32'hFFFF_FFFF);
        else check({tag, " elem"}, 32'(elem), 32'(q_exp.pop_front()));
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
      if (xfer) bi++;
      blk = (bi < NBLK) ? blocks[bi] : {$urandom, $urandom, $urandom, $urandom};
      case (mode)
        1:       elem_ready = 1'($urandom);
        2:       elem_ready = (stall_left == 0);
        default: elem_ready = 1'b1;
      endcase
    end
    if (done_cyc < 0) check({tag, " timeout"}, 32'd0, 32'd1);
    if (mode == 0) check({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_blocks + exp_scan));
    check({tag, " n_elems"}, 32'(got_elems), 32'(n));
    check({tag, " blocks"}, 32'(got_blocks), 32'(exp_blocks));
    check({tag, " rej_cnt"}, 32'(rej_cnt), 32'(exp_rej));
    @(posedge clk); #1;
    blk_valid  = 1'b0;
    elem_ready = 1'b0;
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
    check({tag, " rej_hold"}, 32'(rej_cnt), 32'(exp_rej));
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; n_elems = '0; blk_valid = 1'b0; blk = '0; elem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset outputs", {busy, done, blk_ready, elem_valid, 8'(elem), 16'(rej_cnt)}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Slots 0x00..0x0F, N=4.
    for (int k = 0; k < ELEMS; k++) blocks[0][k*ELEM_W +: ELEM_W] = ELEM_W'(k);
    for (int b = 1; b < NBLK; b++) blocks[b] = {$urandom, $urandom, $urandom, $urandom};
    run_req("ascending", 4, 0);

    // 0xFF and 0xFB rejected ahead of 0xFA, 0x10.
    for (int k = 0; k < ELEMS; k++) blocks[0][k*ELEM_W +: ELEM_W] = ELEM_W'(8'h10 + k);
    blocks[0][31:0] = 32'h10FA_FBFF;
    run_req("rejects", 2, 0);

    // N=20 spans two blocks; second block only partly used.
    for (int k = 0; k < ELEMS; k++) begin
      blocks[0][k*ELEM_W +: ELEM_W] = ELEM_W'(8'h20 + k);
      blocks[1][k*ELEM_W +: ELEM_W] = ELEM_W'(8'h40 + k);
    end
    run_req("two_blocks", 20, 0);

    // Backpressure on the same data.
    run_req("backpressure", 20, 2);

    // Empty request.
    run_req("zero", 0, 0);

    // Reset while an element is being offered.
    for (int k = 0; k < ELEMS; k++) blocks[0][k*ELEM_W +: ELEM_W] = ELEM_W'(8'h30 + k);
    start = 1'b1; n_elems = CNT_W'(4); blk_valid = 1'b1; blk = blocks[0]; elem_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!elem_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst pre valid", 32'(elem_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst outputs", {busy, done, blk_ready, elem_valid, 8'(elem), 16'(rej_cnt)}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; blk_valid = 1'b0;
    blocks[0] = {$urandom, $urandom, $urandom, $urandom};
    blocks[0][7:0] = 8'h5A;
    run_req("after_rst", 1, 0);

    // Randomized requests over random blocks.
    for (int r = 0; r < 6; r++) begin
      for (int b = 0; b < NBLK; b++) blocks[b] = {$urandom, $urandom, $urandom, $urandom};
      for (int b = 0; b < NBLK; b++)
        for (int k = 0; k < ELEMS; k++)
          if ($urandom_range(0, 3) == 0) blocks[b][k*ELEM_W +: ELEM_W] = ELEM_W'($urandom_range(Q, 255));
      run_req("random", int'($urandom_range(1, 60)), r % 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
